// File: rtl/regblock.sv
// Fixed CPU-interface register block: CTRL, STATUS, COUNT, IRQ (W1C), IRQ_EN, SCRATCH.
// Every access is answered exactly one cycle later; there is no stall path.
module regblock (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_cpuif_req,
  input  logic        s_cpuif_req_is_wr,
  input  logic [4:0]  s_cpuif_addr,
  input  logic [31:0] s_cpuif_wr_data,
  input  logic [31:0] s_cpuif_wr_biten,
  output logic        s_cpuif_req_stall_wr,
  output logic        s_cpuif_req_stall_rd,
  output logic        s_cpuif_rd_ack,
  output logic        s_cpuif_rd_err,
  output logic [31:0] s_cpuif_rd_data,
  output logic        s_cpuif_wr_ack,
  output logic        s_cpuif_wr_err,
  input  logic [20:0] hwif_in,
  output logic [16:0] hwif_out
);

  // Handshake: a request is accepted whenever s_cpuif_req=1 and rst=0 (no stall);
  // the matching rd_ack/wr_ack strobes for exactly one cycle on the next cycle,
  // with rd_data/rd_err/wr_err valid only while that strobe is high.

  localparam logic [4:0] ADDR_CTRL    = 5'h00;
  localparam logic [4:0] ADDR_STATUS  = 5'h04;
  localparam logic [4:0] ADDR_COUNT   = 5'h08;
  localparam logic [4:0] ADDR_IRQ     = 5'h0C;
  localparam logic [4:0] ADDR_IRQ_EN  = 5'h10;
  localparam logic [4:0] ADDR_SCRATCH = 5'h14;

  logic        ctrl_en;
  logic [2:0]  ctrl_mode;
  logic [7:0]  count;
  logic [3:0]  irq;
  logic [3:0]  irq_en;
  logic [31:0] scratch;

  logic [15:0] hw_status;
  logic        hw_count_incr;
  logic [3:0]  hw_irq_set;

  assign hw_status     = hwif_in[20:5];
  assign hw_count_incr = hwif_in[4];
  assign hw_irq_set    = hwif_in[3:0];

  logic addr_err;
  logic rd_req;
  logic wr_req;
  logic wr_ok;
  logic rd_ok;

  assign addr_err = (s_cpuif_addr[1:0] != 2'b00) || (s_cpuif_addr >= 5'h18);
  assign rd_req   = s_cpuif_req && !s_cpuif_req_is_wr;
  assign wr_req   = s_cpuif_req && s_cpuif_req_is_wr;
  assign rd_ok    = rd_req && !addr_err;
  assign wr_ok    = wr_req && !addr_err;

  function automatic logic [31:0] rw_merge(input logic [31:0] old_val,
                                           input logic [31:0] data,
                                           input logic [31:0] biten);
    return (old_val & ~biten) | (data & biten);
  endfunction

  logic [31:0] ctrl_merged;
  logic [31:0] count_merged;
  logic [31:0] irq_en_merged;
  logic [31:0] scratch_merged;
  logic [3:0]  irq_clr;
  logic [31:0] rd_mux;

  assign ctrl_merged    = rw_merge({28'b0, ctrl_mode, ctrl_en}, s_cpuif_wr_data, s_cpuif_wr_biten);
  assign count_merged   = rw_merge({24'b0, count}, s_cpuif_wr_data, s_cpuif_wr_biten);
  assign irq_en_merged  = rw_merge({28'b0, irq_en}, s_cpuif_wr_data, s_cpuif_wr_biten);
  assign scratch_merged = rw_merge(scratch, s_cpuif_wr_data, s_cpuif_wr_biten);

  always_comb begin
    irq_clr = 4'b0;
    if (wr_ok && s_cpuif_addr == ADDR_IRQ)
      irq_clr = s_cpuif_wr_data[3:0] & s_cpuif_wr_biten[3:0];
  end

  // STATUS is captured at the same edge that raises rd_ack.
  always_comb begin
    rd_mux = 32'b0;
    case (s_cpuif_addr)
      ADDR_CTRL:    rd_mux = {28'b0, ctrl_mode, ctrl_en};
      ADDR_STATUS:  rd_mux = {16'b0, hw_status};
      ADDR_COUNT:   rd_mux = {24'b0, count};
      ADDR_IRQ:     rd_mux = {28'b0, irq};
      ADDR_IRQ_EN:  rd_mux = {28'b0, irq_en};
      ADDR_SCRATCH: rd_mux = scratch;
      default:      rd_mux = 32'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en         <= 1'b0;
      ctrl_mode       <= 3'b0;
      count           <= 8'b0;
      irq             <= 4'b0;
      irq_en          <= 4'b0;
      scratch         <= 32'b0;
      s_cpuif_rd_ack  <= 1'b0;
      s_cpuif_rd_err  <= 1'b0;
      s_cpuif_rd_data <= 32'b0;
      s_cpuif_wr_ack  <= 1'b0;
      s_cpuif_wr_err  <= 1'b0;
    end else begin
      s_cpuif_rd_ack  <= rd_req;
      s_cpuif_rd_err  <= rd_req && addr_err;
      s_cpuif_rd_data <= rd_ok ? rd_mux : 32'b0;
      s_cpuif_wr_ack  <= wr_req;
      s_cpuif_wr_err  <= wr_req && addr_err;

      if (wr_ok && s_cpuif_addr == ADDR_CTRL) begin
        ctrl_en   <= ctrl_merged[0];
        ctrl_mode <= ctrl_merged[3:1];
      end

      // Software write takes priority over the hardware increment.
      if (wr_ok && s_cpuif_addr == ADDR_COUNT)
        count <= count_merged[7:0];
      else if (hw_count_incr)
        count <= count + 8'd1;

      // Hardware set is OR-ed in after the clear so it wins a collision.
      irq <= (irq & ~irq_clr) | hw_irq_set;

      if (wr_ok && s_cpuif_addr == ADDR_IRQ_EN)
        irq_en <= irq_en_merged[3:0];

      if (wr_ok && s_cpuif_addr == ADDR_SCRATCH)
        scratch <= scratch_merged;
    end
  end

  assign s_cpuif_req_stall_wr = 1'b0;
  assign s_cpuif_req_stall_rd = 1'b0;

  assign hwif_out = {ctrl_en, ctrl_mode, count, irq_en, |(irq & irq_en)};

endmodule

// File: tb/tb_regblock.sv
// Directed bench for regblock: driver tasks push expected responses into a queue,
// a negedge monitor pops and compares each ack and checks one-cycle latency.
module tb_regblock;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_cpuif_req = 1'b0;
  logic        s_cpuif_req_is_wr = 1'b0;
  logic [4:0]  s_cpuif_addr = 5'h0;
  logic [31:0] s_cpuif_wr_data = 32'h0;
  logic [31:0] s_cpuif_wr_biten = 32'h0;
  logic        s_cpuif_req_stall_wr;
  logic        s_cpuif_req_stall_rd;
  logic        s_cpuif_rd_ack;
  logic        s_cpuif_rd_err;
  logic [31:0] s_cpuif_rd_data;
  logic        s_cpuif_wr_ack;
  logic        s_cpuif_wr_err;
  logic [15:0] status = 16'h0;
  logic        count_incr = 1'b0;
  logic [3:0]  irq_set = 4'h0;
  logic [20:0] hwif_in;
  logic [16:0] hwif_out;

  assign hwif_in = {status, count_incr, irq_set};

  regblock dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_cpuif_req          (s_cpuif_req),
    .s_cpuif_req_is_wr    (s_cpuif_req_is_wr),
    .s_cpuif_addr         (s_cpuif_addr),
    .s_cpuif_wr_data      (s_cpuif_wr_data),
    .s_cpuif_wr_biten     (s_cpuif_wr_biten),
    .s_cpuif_req_stall_wr (s_cpuif_req_stall_wr),
    .s_cpuif_req_stall_rd (s_cpuif_req_stall_rd),
    .s_cpuif_rd_ack       (s_cpuif_rd_ack),
    .s_cpuif_rd_err       (s_cpuif_rd_err),
    .s_cpuif_rd_data      (s_cpuif_rd_data),
    .s_cpuif_wr_ack       (s_cpuif_wr_ack),
    .s_cpuif_wr_err       (s_cpuif_wr_err),
    .hwif_in              (hwif_in),
    .hwif_out             (hwif_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Entry layout: {is_wr, err, data[31:0]}
  logic [33:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic exp_rd_ack = 1'b0;
  logic exp_wr_ack = 1'b0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic access(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                        input logic [31:0] biten, input logic [31:0] exp_data, input logic exp_err);
    s_cpuif_req       = 1'b1;
    s_cpuif_req_is_wr = wr;
    s_cpuif_addr      = addr;
    s_cpuif_wr_data   = data;
    s_cpuif_wr_biten  = biten;
    if (!rst) exp_q.push_back({wr, exp_err, wr ? 32'h0 : exp_data});
    @(negedge clk);
    s_cpuif_req = 1'b0;
  endtask

  task automatic wr_reg(input logic [4:0] addr, input logic [31:0] data, input logic [31:0] biten,
                        input logic exp_err);
    access(1'b1, addr, data, biten, 32'h0, exp_err);
  endtask

  task automatic rd_reg(input logic [4:0] addr, input logic [31:0] exp_data, input logic exp_err);
    access(1'b0, addr, 32'h0, 32'h0, exp_data, exp_err);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    mon_en     <= 1'b1;
    exp_rd_ack <= s_cpuif_req && !s_cpuif_req_is_wr && !rst;
    exp_wr_ack <= s_cpuif_req && s_cpuif_req_is_wr && !rst;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      logic [33:0] e;
      checks++;
      if (s_cpuif_rd_ack !== exp_rd_ack || s_cpuif_wr_ack !== exp_wr_ack ||
          s_cpuif_req_stall_rd !== 1'b0 || s_cpuif_req_stall_wr !== 1'b0) begin
        errors++;
        $display("FAIL ack_timing: rd_ack=%b wr_ack=%b stall=%b%b expected rd_ack=%b wr_ack=%b stall=00",
                 s_cpuif_rd_ack, s_cpuif_wr_ack, s_cpuif_req_stall_rd, s_cpuif_req_stall_wr,
                 exp_rd_ack, exp_wr_ack);
      end
      if (s_cpuif_rd_ack !== 1'b1) check("rd_data_idle", s_cpuif_rd_data, 32'h0);
      if (s_cpuif_rd_ack === 1'b1 || s_cpuif_wr_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: rd_ack=%b wr_ack=%b expected no ack", s_cpuif_rd_ack, s_cpuif_wr_ack);
        end else begin
          e = exp_q.pop_front();
          check("ack_kind", {31'b0, s_cpuif_wr_ack}, {31'b0, e[33]});
          if (e[33]) begin
            check("wr_err", {31'b0, s_cpuif_wr_err}, {31'b0, e[32]});
          end else begin
            check("rd_err", {31'b0, s_cpuif_rd_err}, {31'b0, e[32]});
            check("rd_data", s_cpuif_rd_data, e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    // Request during reset must be ignored.
    rd_reg(5'h14, 32'h0, 1'b0);
    idle(1);
    rst = 1'b0;
    check("reset_hwif_out", {15'b0, hwif_out}, 32'h0);

    // All registers read 0 after reset.
    rd_reg(5'h00, 32'h0, 1'b0);
    rd_reg(5'h04, 32'h0, 1'b0);
    rd_reg(5'h08, 32'h0, 1'b0);
    rd_reg(5'h0C, 32'h0, 1'b0);
    rd_reg(5'h10, 32'h0, 1'b0);
    rd_reg(5'h14, 32'h0, 1'b0);
    idle(1);

    // Bit-enabled write, back-to-back with the read.
    wr_reg(5'h14, 32'hDEADBEEF, 32'hFFFF0000, 1'b0);
    rd_reg(5'h14, 32'hDEAD0000, 1'b0);
    idle(1);

    // CTRL and 260 count increments (wraps to 0x04).
    wr_reg(5'h00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    count_incr = 1'b1;
    idle(260);
    count_incr = 1'b0;
    check("ctrl_count_hwif", {15'b0, hwif_out}, {15'b0, 1'b1, 3'b111, 8'h04, 4'h0, 1'b0});
    rd_reg(5'h00, 32'h0000000F, 1'b0);
    rd_reg(5'h08, 32'h00000004, 1'b0);

    // Software write to COUNT beats a simultaneous increment.
    count_incr = 1'b1;
    wr_reg(5'h08, 32'h00000080, 32'hFFFFFFFF, 1'b0);
    count_incr = 1'b0;
    rd_reg(5'h08, 32'h00000080, 1'b0);
    idle(1);

    // IRQ set, enable, W1C and collision.
    irq_set = 4'h5;
    idle(1);
    irq_set = 4'h0;
    wr_reg(5'h10, 32'h00000004, 32'hFFFFFFFF, 1'b0);
    check("irq_asserted", {31'b0, hwif_out[0]}, 32'h1);
    check("irq_en_out", {28'b0, hwif_out[4:1]}, 32'h4);
    wr_reg(5'h0C, 32'h00000004, 32'hFFFFFFFF, 1'b0);
    check("irq_cleared", {31'b0, hwif_out[0]}, 32'h0);
    rd_reg(5'h0C, 32'h00000001, 1'b0);
    wr_reg(5'h0C, 32'h00000001, 32'h00000000, 1'b0);
    rd_reg(5'h0C, 32'h00000001, 1'b0);
    irq_set = 4'h1;
    wr_reg(5'h0C, 32'h00000001, 32'hFFFFFFFF, 1'b0);
    irq_set = 4'h0;
    rd_reg(5'h0C, 32'h00000001, 1'b0);
    idle(1);

    // Out-of-range and misaligned accesses.
    rd_reg(5'h18, 32'h0, 1'b1);
    wr_reg(5'h1C, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wr_reg(5'h15, 32'h00000000, 32'hFFFFFFFF, 1'b1);
    wr_reg(5'h01, 32'h00000000, 32'hFFFFFFFF, 1'b1);
    rd_reg(5'h16, 32'h0, 1'b1);
    rd_reg(5'h14, 32'hDEAD0000, 1'b0);
    rd_reg(5'h00, 32'h0000000F, 1'b0);
    idle(1);

    // STATUS is read-only.
    status = 16'hA5A5;
    rd_reg(5'h04, 32'h0000A5A5, 1'b0);
    wr_reg(5'h04, 32'h12345678, 32'hFFFFFFFF, 1'b0);
    rd_reg(5'h04, 32'h0000A5A5, 1'b0);
    idle(1);

    // Reset with a request pending: dropped, state cleared.
    rst = 1'b1;
    wr_reg(5'h14, 32'h11111111, 32'hFFFFFFFF, 1'b0);
    idle(1);
    rst = 1'b0;
    check("post_reset_hwif_out", {15'b0, hwif_out}, 32'h0);
    rd_reg(5'h14, 32'h0, 1'b0);
    rd_reg(5'h08, 32'h0, 1'b0);

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regblock.md
REGBLOCK -- requirements
Module: regblock

Interface
REQ-001 The block SHALL have no parameters; address width 5, data width 32, and the register map are fixed.
REQ-002 Ports (name direction width meaning), clock and reset first; one clock, synchronous active-high reset:
clk  in  1  rising-edge clock for all logic.
rst  in  1  synchronous active-high reset.
s_cpuif_req  in  1  one-cycle access request.
s_cpuif_req_is_wr  in  1  1 = write, 0 = read.
s_cpuif_addr  in  5  byte address, word aligned.
s_cpuif_wr_data  in  32  write data.
s_cpuif_wr_biten  in  32  per-bit write enable.
s_cpuif_req_stall_wr  out  1  write stall, tied 0.
s_cpuif_req_stall_rd  out  1  read stall, tied 0.
s_cpuif_rd_ack  out  1  read response strobe.
s_cpuif_rd_err  out  1  read error, valid with rd_ack.
s_cpuif_rd_data  out  32  read data, valid with rd_ack.
s_cpuif_wr_ack  out  1  write response strobe.
s_cpuif_wr_err  out  1  write error, valid with wr_ack.
hwif_in  in  21  packed {status[15:0], count_incr, irq_set[3:0]}.
hwif_out  out  17  packed {ctrl_en, ctrl_mode[2:0], count[7:0], irq_en[3:0], irq}.

Function
REQ-003 Register map:
0x00 CTRL: RW; en bit0, mode bits3:1.
0x04 STATUS: RO; bits15:0 = hwif_in.status, sampled at read-ack time.
0x08 COUNT: RW; bits7:0.
0x0C IRQ: W1C; bits3:0.
0x10 IRQ_EN: RW; bits3:0.
0x14 SCRATCH: RW; bits31:0.
REQ-004 Unimplemented bits SHALL read 0 and ignore writes.
REQ-005 Writes SHALL update only bits where wr_biten=1: RW gets new = (old & ~biten) | (data & biten); W1C clears bits where data & biten = 1.
REQ-006 Response latency SHALL be exactly one cycle: a request in cycle N gives rd_ack or wr_ack high in cycle N+1 for one cycle; register state updates at the same edge.
REQ-007 Stall outputs SHALL always be 0; back-to-back requests on consecutive cycles SHALL each get their own ack.
REQ-008 Addresses 0x18-0x1F or not word-aligned SHALL be acked with err=1 and rd_data=0, and SHALL change no state; all other accesses give err=0.
REQ-009 rd_data SHALL be 0 whenever rd_ack=0.
REQ-010 COUNT SHALL increment by 1 on each cycle with hwif_in.count_incr=1, wrapping 0xFF to 0x00.
REQ-011 When a software write to COUNT and count_incr fall in the same cycle, the software write SHALL win.
REQ-012 IRQ bit i SHALL set when irq_set[i]=1; hardware set SHALL win over a simultaneous W1C clear.
REQ-013 hwif_out.irq SHALL be combinational |(IRQ & IRQ_EN).
REQ-014 The other hwif_out fields SHALL come straight from the register flops.
REQ-015 STATUS writes SHALL be acked with err=0 and SHALL have no effect.

Reset
REQ-016 With rst=1 at a clock edge, CTRL, COUNT, IRQ, IRQ_EN, SCRATCH SHALL become 0, and rd_ack and wr_ack SHALL become 0.
REQ-017 A request pending during reset SHALL be dropped with no ack.
REQ-018 All outputs SHALL be free of X/Z from the first edge with rst=1 onward.
REQ-019 Requests issued while rst=1 SHALL be ignored.

Verification
REQ-020 Reset, then read every register -> all 0, err=0; hwif_out = 0.
REQ-021 Write SCRATCH 0xDEADBEEF, biten 0xFFFF0000, then read -> 0xDEAD0000, each ack one cycle after its req.
REQ-022 Write CTRL 0xF, then hold count_incr high for 260 cycles -> ctrl_en=1, ctrl_mode=7, COUNT = 0x04 (wrapped).
REQ-023 Pulse irq_set=0x5 and write IRQ_EN=0x4 -> irq=1; W1C 0x4 -> irq=0 and IRQ reads 0x1; W1C in the same cycle as an irq_set pulse -> bit stays set.
REQ-024 Read 0x18 and write 0x1C -> rd_err=1 with data 0, wr_err=1, no state change.
REQ-025 Drive status=0xA5A5 and read 0x04 -> 0x0000A5A5; then write 0x04 -> register unchanged.
